// File: rtl/root_chain_seq.sv
// Multi-cycle evaluator of y = floor(sqrt(a + floor(cbrt(b)))) with a start/busy/valid handshake.
// Restoring digit-serial cube root, one-cycle add, then restoring digit-serial square root.
module root_chain_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] a_bi,
    input  logic [W-1:0] b_bi,
    output logic         busy_o,
    output logic         valid_o,
    output logic [W-1:0] y_bo
);

    localparam int unsigned CBW  = (W + 2) / 3;
    localparam int unsigned SQW  = (W + 2) / 2;
    localparam int unsigned BPW  = 3 * CBW;
    localparam int unsigned CRW  = 3 * CBW + 4;
    localparam int unsigned SPW  = 2 * SQW;
    localparam int unsigned SRW  = SQW + 3;
    localparam int unsigned CNTW = 5;

    typedef enum logic [1:0] {StIdle, StCbrt, StSum, StSqrt} state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      a_q, a_d;
    logic [BPW-1:0]    bp_q, bp_d;
    logic [CRW-4:0]    crem_q, crem_d;
    logic [CBW-1:0]    c_q, c_d;
    logic [SPW-1:0]    sp_q, sp_d;
    logic [SRW-3:0]    srem_q, srem_d;
    logic [SQW-1:0]    r_q, r_d;
    logic [W-1:0]      y_q, y_d;
    logic              valid_q, valid_d;

    // Cube-root step: remainder is relative to (2c)^3, trial term is (2c+1)^3 - (2c)^3.
    logic [CRW-1:0] c_rem_sh, c_y2w, c_t;
    logic [CBW-1:0] c_y2, c_new;
    logic           c_ge;

    // Square-root step: remainder is relative to (2r)^2, trial term is 4r+1.
    logic [SRW-1:0] s_rem_sh, s_t;
    logic [SQW-1:0] r_y2, r_new;
    logic           s_ge;
    logic [W:0]     sum_w;

    always_comb begin
        c_rem_sh = {crem_q, bp_q[BPW-1 -: 3]};
        c_y2     = {c_q[CBW-2:0], 1'b0};
        c_y2w    = CRW'(c_y2);
        c_t      = (c_y2w * (c_y2w + CRW'(1))) * CRW'(3) + CRW'(1);
        c_ge     = (c_rem_sh >= c_t);
        c_new    = c_ge ? (c_y2 | CBW'(1)) : c_y2;

        s_rem_sh = {srem_q, sp_q[SPW-1 -: 2]};
        s_t      = (SRW'(r_q) << 2) | SRW'(1);
        s_ge     = (s_rem_sh >= s_t);
        r_y2     = {r_q[SQW-2:0], 1'b0};
        r_new    = s_ge ? (r_y2 | SQW'(1)) : r_y2;

        sum_w    = {1'b0, a_q} + (W+1)'(c_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        bp_d    = bp_q;
        crem_d  = crem_q;
        c_d     = c_q;
        sp_d    = sp_q;
        srem_d  = srem_q;
        r_d     = r_q;
        y_d     = y_q;
        valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = a_bi;
                    bp_d    = BPW'(b_bi);
                    crem_d  = '0;
                    c_d     = '0;
                    srem_d  = '0;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = StCbrt;
                end
            end
            StCbrt: begin
                bp_d   = bp_q << 3;
                crem_d = (CRW-3)'(c_ge ? (c_rem_sh - c_t) : c_rem_sh);
                c_d    = c_new;
                if (cnt_q == CNTW'(CBW - 1)) begin
                    cnt_d   = '0;
                    state_d = StSum;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            StSum: begin
                sp_d    = SPW'(sum_w);
                state_d = StSqrt;
            end
            StSqrt: begin
                sp_d   = sp_q << 2;
                srem_d = (SRW-2)'(s_ge ? (s_rem_sh - s_t) : s_rem_sh);
                r_d    = r_new;
                if (cnt_q == CNTW'(SQW - 1)) begin
                    cnt_d   = '0;
                    y_d     = W'(r_new);
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            bp_q    <= '0;
            crem_q  <= '0;
            c_q     <= '0;
            sp_q    <= '0;
            srem_q  <= '0;
            r_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            bp_q    <= bp_d;
            crem_q  <= crem_d;
            c_q     <= c_d;
            sp_q    <= sp_d;
            srem_q  <= srem_d;
            r_q     <= r_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign valid_o = valid_q;
    assign y_bo    = y_q;

endmodule

// File: tb/tb_root_chain_seq.sv
// Scoreboard bench for root_chain_seq at W=8 and W=16; expected results come from a
// brute-force integer model of floor(sqrt(a + floor(cbrt(b)))).
module tb_root_chain_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, st8, busy8, v8;
    logic [7:0]  a8, b8, y8;
    logic        rst16, st16, busy16, v16;
    logic [15:0] a16, b16, y16;

    root_chain_seq #(.W(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst8), .start_i(st8), .a_bi(a8), .b_bi(b8),
        .busy_o(busy8), .valid_o(v8), .y_bo(y8)
    );

    root_chain_seq #(.W(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst16), .start_i(st16), .a_bi(a16), .b_bi(b16),
        .busy_o(busy16), .valid_o(v16), .y_bo(y16)
    );

    int     n_chk  = 0;
    int     n_pass = 0;
    longint q8[$];
    longint q16[$];
    int     run8   = 0;
    int     run16  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint ref_y(input longint a, input longint b);
        longint c = 0;
        longint y = 0;
        longint s;
        while ((c + 1) * (c + 1) * (c + 1) <= b) c++;
        s = a + c;
        while ((y + 1) * (y + 1) <= s) y++;
        return y;
    endfunction

    // Monitor: pops expected results on valid, checks latency and busy/valid alignment.
    initial begin
        forever begin
            @(negedge clk);
            if (rst8) run8 = 0;
            else begin
                if (v8) begin
                    if (q8.size() == 0) check("v8_unexpected", 1, 0);
                    else begin
                        check("y8", y8, q8.pop_front());
                        check("lat8", run8, 9);
                    end
                end
                if (busy8) run8++;
                else begin
                    if (run8 != 0) check("vpulse8", v8, 1);
                    run8 = 0;
                end
            end
            if (rst16) run16 = 0;
            else begin
                if (v16) begin
                    if (q16.size() == 0) check("v16_unexpected", 1, 0);
                    else begin
                        check("y16", y16, q16.pop_front());
                        check("lat16", run16, 16);
                    end
                end
                if (busy16) run16++;
                else begin
                    if (run16 != 0) check("vpulse16", v16, 1);
                    run16 = 0;
                end
            end
        end
    end

    // Drive start for n cycles from a negedge; every cycle seen idle is an acceptance.
    task automatic start8(input longint a, input longint b, input int n);
        a8 = 8'(a); b8 = 8'(b); st8 = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (!busy8 && !rst8) q8.push_back(ref_y(a, b));
            @(negedge clk);
        end
        st8 = 1'b0;
    endtask

    task automatic start16(input longint a, input longint b, input int n);
        a16 = 16'(a); b16 = 16'(b); st16 = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (!busy16 && !rst16) q16.push_back(ref_y(a, b));
            @(negedge clk);
        end
        st16 = 1'b0;
    endtask

    task automatic wait_idle8();
        int k = 0;
        while ((busy8 || q8.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain8", q8.size(), 0);
    endtask

    task automatic wait_idle16();
        int k = 0;
        while ((busy16 || q16.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain16", q16.size(), 0);
    endtask

    initial begin
        rst8 = 1'b1; rst16 = 1'b1; st8 = 1'b0; st16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        #3;
        check("rst_busy8", busy8, 0);
        check("rst_valid8", v8, 0);
        check("rst_y8", y8, 0);
        check("rst_busy16", busy16, 0);
        check("rst_valid16", v16, 0);
        check("rst_y16", y16, 0);
        @(negedge clk);
        @(negedge clk);
        rst8 = 1'b0; rst16 = 1'b0;
        @(negedge clk);

        // Directed W=8 cases
        start8(0, 0, 1);     wait_idle8();
        start8(13, 27, 1);   wait_idle8();
        check("y8_13_27", y8, 4);
        start8(10, 7, 1);    wait_idle8();
        check("y8_10_7", y8, 3);
        start8(255, 255, 1); wait_idle8();
        check("y8_max", y8, 16);

        // Start while busy is ignored
        start8(13, 27, 1);
        repeat (3) @(negedge clk);
        start8(0, 0, 1);
        wait_idle8();
        check("y8_ignored", y8, 4);

        // Start held high: back-to-back acceptances every 10 cycles
        start8(13, 27, 31);
        wait_idle8();

        // Abort by reset at busy cycle 5
        start8(100, 200, 1);
        repeat (4) @(negedge clk);
        #2 rst8 = 1'b1;
        #1;
        check("abort_busy8", busy8, 0);
        check("abort_y8", y8, 0);
        check("abort_valid8", v8, 0);
        void'(q8.pop_back());
        @(negedge clk);
        #2 rst8 = 1'b0;
        repeat (15) @(negedge clk);
        start8(3, 1, 1);
        wait_idle8();
        check("y8_after_abort", y8, 2);

        // Random W=8: restart on the valid cycle, scramble operands while busy
        for (int i = 0; i < 40; i++) begin
            int k = 0;
            start8(longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)), 1);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            while (busy8 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        wait_idle8();

        // W=16
        start16(65535, 65535, 1); wait_idle16();
        check("y16_max", y16, 256);
        for (int i = 0; i < 30; i++) begin
            int k = 0;
            start16(longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)), 1);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            while (busy16 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        wait_idle16();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
